// File: rtl/regfile_master.sv
// Initiator-side controller for a 2^ADDR_W x DATA_W register file: single write/read plus bulk
// fill and scan-verify, driven through a Start/Busy/Done handshake. Optional macro: SKIP_R0_EN.
module regfile_master #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEDSIZE = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data,
    input  logic [1:0]        CS,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Rd_Data,
    output logic [ADDR_W:0]   Err_Count,
    output logic [LEDSIZE-1:0] LED
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LastIdx  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] LastScan = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StFill, StScan, StDone} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;
    logic [ADDR_W-1:0]  r_addr_a_q, r_addr_a_d;
    logic [ADDR_W-1:0]  r_addr_b_q, r_addr_b_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [CntW-1:0]    err_q, err_d;
    logic [LEDSIZE-1:0] led_q, led_d;
    logic [DATA_W-1:0]  exp_a, exp_b;
    logic               mis_a, mis_b;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            r_addr_a_q <= '0;
            r_addr_b_q <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            err_q      <= '0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            r_addr_a_q <= r_addr_a_d;
            r_addr_b_q <= r_addr_b_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            led_q      <= led_d;
        end
    end

    // Scan expects each entry to hold pattern base plus its own address.
    always_comb begin
        exp_a = data_q + DATA_W'(r_addr_a_q);
        exp_b = data_q + DATA_W'(r_addr_b_q);
`ifdef SKIP_R0_EN
        if (r_addr_a_q == '0) begin
            exp_a = '0;
        end
`endif
        mis_a = (R_Data_A != exp_a);
        mis_b = (R_Data_B != exp_b);
    end

    always_comb begin
        state_d    = state_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        r_addr_a_d = r_addr_a_q;
        r_addr_b_d = r_addr_b_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    data_d = Data;
                    unique case (Op)
                        2'b00: begin
                            state_d  = StWrite;
                            w_addr_d = Address;
                            w_data_d = Data;
                        end
                        2'b01: begin
                            state_d    = StRead;
                            r_addr_a_d = Address;
                        end
                        2'b10: begin
                            state_d  = StFill;
                            w_addr_d = '0;
                            w_data_d = Data;
                        end
                        2'b11: begin
                            state_d    = StScan;
                            r_addr_a_d = '0;
                            r_addr_b_d = ADDR_W'(1);
                            err_d      = '0;
                        end
                    endcase
                end
            end
            StWrite: state_d = StDone;
            StRead: begin
                rd_data_d = R_Data_A;
                state_d   = StDone;
            end
            StFill: begin
                if (w_addr_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    w_addr_d = w_addr_q + ADDR_W'(1);
                    w_data_d = w_data_q + DATA_W'(1);
                end
            end
            StScan: begin
                err_d = err_q + CntW'(mis_a) + CntW'(mis_b);
                if (r_addr_a_q == LastScan) begin
                    state_d = StDone;
                end else begin
                    r_addr_a_d = r_addr_a_q + ADDR_W'(2);
                    r_addr_b_d = r_addr_b_q + ADDR_W'(2);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        led_d = rd_data_q[LEDSIZE-1:0];
        for (int unsigned k = 0; k < DATA_W / LEDSIZE; k++) begin
            if (CS == 2'(k)) begin
                led_d = rd_data_q[k*LEDSIZE +: LEDSIZE];
            end
        end
    end

    always_comb begin
        Write_Reg = (state_q == StWrite) || (state_q == StFill);
`ifdef SKIP_R0_EN
        if (w_addr_q == '0) begin
            Write_Reg = 1'b0;
        end
`endif
    end

    assign Busy      = (state_q == StWrite) || (state_q == StRead) ||
                       (state_q == StFill) || (state_q == StScan);
    assign Done      = (state_q == StDone);
    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;
    assign R_Addr_A  = r_addr_a_q;
    assign R_Addr_B  = r_addr_b_q;
    assign Rd_Data   = rd_data_q;
    assign Err_Count = err_q;
    assign LED       = led_q;

endmodule
